// File: rtl/mem_arbiter.sv
// Arbitrates one multi-cycle memory between the I-fill, D-fill and write-through paths,
// sequencing 8-word block reads. Define MEM_ARB_RR_EN for round-robin between D and I fills.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_grant,
    output logic              i_done,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_grant,
    output logic              d_done,
    input  logic              w_req,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic              w_ack,
    output logic [DATA_W-1:0] fill_data,
    output logic [2:0]        fill_word,
    output logic              i_fill_valid,
    output logic              d_fill_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_en,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdata_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IFILL = 2'd1,
        DFILL = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'(15);

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_issue_cnt, w_issue_nxt;
    logic [3:0]        r_rx_cnt, w_rx_nxt;
    logic [ADDR_W-1:0] r_base, w_base_nxt;
    logic              r_i_done, r_d_done;
    logic              w_i_done_nxt, w_d_done_nxt;
    logic              w_pick_d;

`ifdef MEM_ARB_RR_EN
    // 0 = last fill served was I, 1 = D; the other type wins a tie.
    logic r_last_fill;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_fill <= 1'b0;
        end else if (r_state == IDLE && !w_req && (d_req || i_req)) begin
            r_last_fill <= w_pick_d;
        end
    end

    assign w_pick_d = d_req && (!i_req || !r_last_fill);
`else
    assign w_pick_d = d_req;
`endif

    assign i_done = r_i_done;
    assign d_done = r_d_done;

    // NOTE: every output and next-state value gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_issue_nxt  = r_issue_cnt;
        w_rx_nxt     = r_rx_cnt;
        w_base_nxt   = r_base;
        w_i_done_nxt = 1'b0;
        w_d_done_nxt = 1'b0;
        i_grant      = 1'b0;
        d_grant      = 1'b0;
        w_ack        = 1'b0;
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        fill_data    = '0;
        fill_word    = '0;
        i_fill_valid = 1'b0;
        d_fill_valid = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_state_nxt = WRITE;
                    w_base_nxt  = w_addr & BLOCK_MASK;
                end else if (w_pick_d) begin
                    w_state_nxt = DFILL;
                    w_base_nxt  = d_addr & BLOCK_MASK;
                end else if (i_req) begin
                    w_state_nxt = IFILL;
                    w_base_nxt  = i_addr & BLOCK_MASK;
                end
            end

            WRITE: begin
                mem_en      = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = w_addr;
                mem_wdata   = w_data;
                w_ack       = 1'b1;
                w_state_nxt = IDLE;
            end

            IFILL, DFILL: begin
                i_grant = (r_state == IFILL);
                d_grant = (r_state == DFILL);

                if (r_issue_cnt < 4'(WORDS)) begin
                    mem_en      = 1'b1;
                    mem_addr    = r_base + ADDR_W'({r_issue_cnt, 1'b0});
                    w_issue_nxt = r_issue_cnt + 4'd1;
                end

                // Returns arrive in issue order, so rx_cnt alone names the word.
                if (mem_rdata_valid) begin
                    fill_data    = mem_rdata;
                    fill_word    = r_rx_cnt[2:0];
                    i_fill_valid = (r_state == IFILL);
                    d_fill_valid = (r_state == DFILL);
                    w_rx_nxt     = r_rx_cnt + 4'd1;
                    if (r_rx_cnt == 4'(WORDS - 1)) begin
                        w_state_nxt  = IDLE;
                        w_issue_nxt  = 4'd0;
                        w_rx_nxt     = 4'd0;
                        w_i_done_nxt = (r_state == IFILL);
                        w_d_done_nxt = (r_state == DFILL);
                    end
                end
            end

            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_issue_cnt <= 4'd0;
            r_rx_cnt    <= 4'd0;
            r_base      <= '0;
            r_i_done    <= 1'b0;
            r_d_done    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_issue_cnt <= w_issue_nxt;
            r_rx_cnt    <= w_rx_nxt;
            r_base      <= w_base_nxt;
            r_i_done    <= w_i_done_nxt;
            r_d_done    <= w_d_done_nxt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a fixed-latency memory model plus
// scoreboards for memory accesses and returned fill words.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0, w_req = 1'b0;
    logic [15:0] i_addr = '0, d_addr = '0, w_addr = '0, w_data = '0;
    logic        i_grant, i_done, d_grant, d_done, w_ack;
    logic [15:0] fill_data, mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  fill_word;
    logic        i_fill_valid, d_fill_valid, mem_en, mem_wr, mem_rdata_valid;

    logic        mdl_valid = 1'b0;
    logic [15:0] mdl_data = '0;
    logic        spur_valid = 1'b0;
    logic [15:0] spur_data = '0;

    assign mem_rdata_valid = mdl_valid | spur_valid;
    assign mem_rdata       = spur_valid ? spur_data : mdl_data;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_done(i_done),
        .d_req(d_req), .d_addr(d_addr), .d_grant(d_grant), .d_done(d_done),
        .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_ack(w_ack),
        .fill_data(fill_data), .fill_word(fill_word),
        .i_fill_valid(i_fill_valid), .d_fill_valid(d_fill_valid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_en(mem_en), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid)
    );

    typedef struct packed {logic wr; logic [15:0] addr; logic [15:0] wdata;} acc_t;
    typedef struct packed {logic iv; logic dv; logic [2:0] word; logic [15:0] data;} fill_t;

    acc_t        exp_acc[$];
    fill_t       exp_fill[$];
    logic [15:0] pend_addr[$];
    int          pend_due[$];
    int          checks = 0, errors = 0;
    int          cyc = 0, lat = 4, last7_cyc = -10, ack_cnt = 0;

    function automatic logic [15:0] mdata(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [59:0] all_outs();
        return {i_grant, i_done, d_grant, d_done, w_ack, fill_data, fill_word,
                i_fill_valid, d_fill_valid, mem_addr, mem_wdata, mem_en, mem_wr};
    endfunction

    task automatic push_fill(input bit is_d, input logic [15:0] base, input int n_fill);
        logic [15:0] a;
        for (int k = 0; k < 8; k++) begin
            a = 16'(base + 16'(2 * k));
            exp_acc.push_back('{wr: 1'b0, addr: a, wdata: 16'h0000});
            if (k < n_fill) exp_fill.push_back('{iv: !is_d, dv: is_d, word: k[2:0], data: mdata(a)});
        end
    endtask

    // Ends in the done cycle with the finished requester's req dropped.
    task automatic wait_done(input bit is_d, input string tag);
        int n;
        n = 0;
        while ((is_d ? d_done : i_done) !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, is_d ? d_done : i_done, 64'd1);
        check({tag, "_done_lat"}, cyc, last7_cyc + 1);
        check({tag, "_grant_drop"}, {i_grant, d_grant}, 64'd0);
        if (is_d) d_req = 1'b0;
        else i_req = 1'b0;
    endtask

    // Fixed-latency in-order memory: a read issued in cycle c returns in cycle c+lat.
    always @(posedge clk) begin
        if (mem_en === 1'b1 && mem_wr === 1'b0) begin
            pend_addr.push_back(mem_addr);
            pend_due.push_back(cyc + lat);
        end
        cyc = cyc + 1;
        #1;
        if (pend_due.size() > 0 && pend_due[0] == cyc) begin
            mdl_valid <= 1'b1;
            mdl_data  <= mdata(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            mdl_valid <= 1'b0;
            mdl_data  <= 16'h0000;
        end
    end

    always @(negedge clk) begin
        acc_t  a;
        fill_t f;
        if (mem_en === 1'b1) begin
            if (exp_acc.size() == 0) begin
                check("unexpected_access", mem_en, 64'd0);
            end else begin
                a = exp_acc.pop_front();
                check("mem_access", {mem_wr, mem_addr, mem_wdata}, a);
            end
        end
        if (i_fill_valid === 1'b1 || d_fill_valid === 1'b1) begin
            if (exp_fill.size() == 0) begin
                check("unexpected_fill", {i_fill_valid, d_fill_valid}, 64'd0);
            end else begin
                f = exp_fill.pop_front();
                check("fill_word", {i_fill_valid, d_fill_valid, fill_word, fill_data}, f);
                if (fill_word == 3'd7) last7_cyc = cyc;
            end
        end
        if (w_ack === 1'b1) ack_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cnt, fv, pulses, ack0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single I-fill, latency 4
        lat = 4;
        push_fill(1'b0, 16'h1230, 8);
        i_addr = 16'h1236;
        i_req  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("ifill_issue", {i_grant, d_grant, mem_en, mem_addr}, {3'b101, 16'(16'h1230 + 2 * k)});
        end
        wait_done(1'b0, "ifill");
        @(negedge clk);
        check("ifill_done_pulse", {i_done, d_done, i_grant}, 64'd0);

        // Simultaneous write, D-fill and I-fill: W, then D, then I
        lat = 2;
        exp_acc.push_back('{wr: 1'b1, addr: 16'h4002, wdata: 16'hCAFE});
        push_fill(1'b1, 16'h2F10, 8);
        push_fill(1'b0, 16'h0C00, 8);
        w_addr = 16'h4002; w_data = 16'hCAFE; w_req = 1'b1;
        d_addr = 16'h2F1A; d_req = 1'b1;
        i_addr = 16'h0C04; i_req = 1'b1;
        @(negedge clk);
        check("prio_write", {w_ack, mem_en, mem_wr, mem_addr, mem_wdata}, {3'b111, 16'h4002, 16'hCAFE});
        w_req = 1'b0;
        @(negedge clk);
        check("prio_idle_no_access", {mem_en, i_grant, d_grant, w_ack}, 64'd0);
        @(negedge clk);
        check("prio_d_first", {d_grant, i_grant}, 64'b10);
        wait_done(1'b1, "prio_d");
        @(negedge clk);
        check("prio_i_next", {i_grant, d_grant, mem_addr}, {2'b10, 16'h0C00});
        wait_done(1'b0, "prio_i");
        @(negedge clk);

        // Write raised mid-fill waits for the fill to finish
        lat = 3;
        push_fill(1'b1, 16'h0100, 8);
        exp_acc.push_back('{wr: 1'b1, addr: 16'h0206, wdata: 16'h1234});
        d_addr = 16'h0104; d_req = 1'b1;
        repeat (3) @(negedge clk);
        ack0 = ack_cnt;
        w_addr = 16'h0206; w_data = 16'h1234; w_req = 1'b1;
        wait_done(1'b1, "midw");
        check("midw_no_early_ack", ack_cnt, ack0);
        @(negedge clk);
        check("midw_ack", {w_ack, mem_wr, mem_addr, mem_wdata}, {2'b11, 16'h0206, 16'h1234});
        w_req = 1'b0;
        @(negedge clk);
        check("midw_ack_pulse", w_ack, 64'd0);

        // Reset after 3 returns; the 5 stale returns must be ignored
        lat = 6;
        push_fill(1'b0, 16'h3450, 3);
        i_addr = 16'h345A; i_req = 1'b1;
        n = 0; cnt = 0;
        while (cnt < 3 && n < 100) begin
            @(negedge clk);
            n++;
            if (i_fill_valid === 1'b1) cnt++;
        end
        check("rst_three_returns", cnt, 64'd3);
        rst = 1'b1; i_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rst_outputs_zero", all_outs(), 64'd0);
        pulses = (mem_rdata_valid === 1'b1) ? 1 : 0;
        fv = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_rdata_valid === 1'b1) pulses++;
            if (i_fill_valid === 1'b1 || d_fill_valid === 1'b1) fv++;
        end
        check("rst_stale_pulses", pulses, 64'd5);
        check("rst_no_fill_valid", fv, 64'd0);
        lat = 2;
        push_fill(1'b0, 16'h3450, 8);
        i_addr = 16'h3450; i_req = 1'b1;
        @(negedge clk);
        check("restart_word0", {i_grant, mem_en, mem_addr}, {2'b11, 16'h3450});
        wait_done(1'b0, "restart");
        @(negedge clk);

        // Spurious return in IDLE
        spur_data = 16'hBEEF; spur_valid = 1'b1;
        #1;
        check("spur_no_fill", {i_fill_valid, d_fill_valid, fill_data}, 64'd0);
        @(negedge clk);
        spur_valid = 1'b0;
        check("spur_stay_idle", {i_grant, d_grant, mem_en, i_done, d_done}, 64'd0);

        repeat (4) @(negedge clk);
        check("acc_queue_drained", exp_acc.size(), 64'd0);
        check("fill_queue_drained", exp_fill.size(), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
